// File: rtl/missile_unit.sv
// missile_unit: pool of ship missiles stepped once per frame,
// spawned on fire edges and drawn as 2x2 white squares.
// Ports:
//   clk, resetN      clock; async reset, active HIGH despite name
//   fire             fire button level (rising edge requests)
//   frame_tick       1-cycle pulse at start of vertical blank
//   ship_x/ship_y    ship centre in pixels
//   sin_val/cos_val  ship heading, Q.16 signed (1.0 = 65536)
//   pxl_x/pxl_y      current scan pixel
//   collision        drawn missile pixel hit another object
//   Red/Green/Blue   pixel colour
//   Draw             missile pixel present (1-cycle latency)
//   active           per-slot alive mask
module missile_unit #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int NUM_MISSILES = 4,
  parameter int LIFETIME     = 60,
  parameter int COOLDOWN     = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    fire,
  input  logic                    frame_tick,
  input  logic [XW-1:0]           ship_x,
  input  logic [YW-1:0]           ship_y,
  input  logic signed [17:0]      sin_val,
  input  logic signed [17:0]      cos_val,
  input  logic [XW-1:0]           pxl_x,
  input  logic [YW-1:0]           pxl_y,
  input  logic                    collision,
  output logic [3:0]              Red,
  output logic [3:0]              Green,
  output logic [3:0]              Blue,
  output logic                    Draw,
  output logic [NUM_MISSILES-1:0] active
);

  localparam int IW =
    (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
  localparam int CW =
    (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int XSW = XW + 8;
  localparam int YSW = YW + 8;
  localparam logic signed [XSW-1:0] XLIM =
    XSW'(WIDTH * 64);
  localparam logic signed [YSW-1:0] YLIM =
    YSW'(HEIGHT * 64);
  localparam logic [IW-1:0] LAST =
    IW'(NUM_MISSILES - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN
  } state_t;

  state_t state, state_nx;

  logic [XW+5:0]      pos_x [NUM_MISSILES];
  logic [YW+5:0]      pos_y [NUM_MISSILES];
  logic signed [10:0] vel_x [NUM_MISSILES];
  logic signed [10:0] vel_y [NUM_MISSILES];
  logic [6:0]         age   [NUM_MISSILES];
  logic [NUM_MISSILES-1:0] alive;

  logic [IW-1:0] slot;
  logic [IW-1:0] free_sel;
  logic [IW-1:0] hit_sel;
  logic [IW-1:0] draw_idx;
  logic          free_any;
  logic          hit;
  logic          fire_q;
  logic          fire_pending;
  logic [CW-1:0] cooldown;
  logic [XW:0]   dx;
  logic [YW:0]   dy;

  logic signed [10:0] vx_new;
  logic signed [10:0] vy_new;
  logic               unused_bits;

  // >>>8 of a Q.16 heading is just its upper bits.
  assign vx_new = {cos_val[17], cos_val[17:8]};
  assign vy_new = -{sin_val[17], sin_val[17:8]};
  assign unused_bits = ^{cos_val[7:0], sin_val[7:0]};

  assign active = alive;
  assign Red    = {4{Draw}};
  assign Green  = {4{Draw}};
  assign Blue   = {4{Draw}};

  // Velocity is at most 8 px/frame, so one wrap suffices.
  function automatic logic [XW+5:0] step_x(
    input logic [XW+5:0]      p,
    input logic signed [10:0] v
  );
    logic signed [XSW-1:0] s;
    s = $signed({2'b00, p}) + XSW'(v);
    if (s >= XLIM)
      s = s - XLIM;
    else if (s[XSW-1])
      s = s + XLIM;
    return s[XW+5:0];
  endfunction

  function automatic logic [YW+5:0] step_y(
    input logic [YW+5:0]      p,
    input logic signed [10:0] v
  );
    logic signed [YSW-1:0] s;
    s = $signed({2'b00, p}) + YSW'(v);
    if (s >= YLIM)
      s = s - YLIM;
    else if (s[YSW-1])
      s = s + YLIM;
    return s[YW+5:0];
  endfunction

  // Descending scan so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    dx      = '0;
    dy      = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      dx = {1'b0, pxl_x} - {1'b0, pos_x[i][XW+5:6]};
      dy = {1'b0, pxl_y} - {1'b0, pos_y[i][YW+5:6]};
      if (alive[i] && dx[XW:1] == '0
          && dy[YW:1] == '0) begin
        hit     = 1'b1;
        hit_sel = IW'(i);
      end
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_sel = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      if (!alive[i]) begin
        free_any = 1'b1;
        free_sel = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_tick) state_nx = UPDATE;
      UPDATE:  if (slot == LAST) state_nx = SPAWN;
      SPAWN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      fire_q       <= 1'b0;
      fire_pending <= 1'b0;
      cooldown     <= '0;
      slot         <= '0;
      Draw         <= 1'b0;
      draw_idx     <= '0;
      alive        <= '0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        age[i]   <= '0;
      end
    end else begin
      fire_q <= fire;
      // A new edge beats the SPAWN clear.
      if (fire && !fire_q)
        fire_pending <= 1'b1;
      else if (state == SPAWN)
        fire_pending <= 1'b0;

      Draw     <= hit;
      draw_idx <= hit_sel;

      if (state == UPDATE) begin
        slot <= slot + 1'b1;
        if (alive[slot]) begin
          pos_x[slot] <= step_x(pos_x[slot], vel_x[slot]);
          pos_y[slot] <= step_y(pos_y[slot], vel_y[slot]);
          age[slot]   <= age[slot] - 7'd1;
          if (age[slot] == 7'd1)
            alive[slot] <= 1'b0;
        end
      end else begin
        slot <= '0;
      end

      if (state == SPAWN) begin
        if (fire_pending && cooldown == '0
            && free_any) begin
          pos_x[free_sel] <= {ship_x, 6'd0};
          pos_y[free_sel] <= {ship_y, 6'd0};
          vel_x[free_sel] <= vx_new;
          vel_y[free_sel] <= vy_new;
          age[free_sel]   <= 7'(LIFETIME);
          alive[free_sel] <= 1'b1;
          cooldown        <= CW'(COOLDOWN);
        end else if (cooldown != '0) begin
          cooldown <= cooldown - 1'b1;
        end
      end

      // Last assignment: a kill overrides a same-cycle update.
      if (collision && Draw)
        alive[draw_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_missile_unit.sv
// tb_missile_unit: directed tests for missile_unit against a
// frame-level behavioural model plus literal expectations.
module tb_missile_unit;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int NM = 4;
  localparam int LT = 60;
  localparam int CD = 8;

  logic              clk = 1'b0;
  logic              resetN;
  logic              fire;
  logic              frame_tick;
  logic [9:0]        ship_x;
  logic [8:0]        ship_y;
  logic signed [17:0] sin_val;
  logic signed [17:0] cos_val;
  logic [9:0]        pxl_x;
  logic [8:0]        pxl_y;
  logic              collision;
  logic [3:0]        Red, Green, Blue;
  logic              Draw;
  logic [NM-1:0]     active;

  missile_unit #(
    .WIDTH(W), .HEIGHT(H), .NUM_MISSILES(NM),
    .LIFETIME(LT), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .resetN(resetN), .fire(fire),
    .frame_tick(frame_tick),
    .ship_x(ship_x), .ship_y(ship_y),
    .sin_val(sin_val), .cos_val(cos_val),
    .pxl_x(pxl_x), .pxl_y(pxl_y),
    .collision(collision),
    .Red(Red), .Green(Green), .Blue(Blue),
    .Draw(Draw), .active(active)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit busy     = 1'b1;

  // Model: positions in 1/64 px units.
  int m_x [NM];
  int m_y [NM];
  int m_vx[NM];
  int m_vy[NM];
  int m_age[NM];
  bit m_alive[NM];
  bit m_pend;
  int m_cd;
  bit p_draw;
  int p_idx;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, got, want);
    end
  endtask

  function automatic int wrap(int v, int lim);
    return ((v % lim) + lim) % lim;
  endfunction

  function automatic logic [NM-1:0] m_active();
    logic [NM-1:0] a;
    for (int i = 0; i < NM; i++) a[i] = m_alive[i];
    return a;
  endfunction

  function automatic bit covers(int i, int x, int y);
    int xi, yi;
    xi = m_x[i] / 64;
    yi = m_y[i] / 64;
    return x >= xi && x <= xi + 1 && y >= yi && y <= yi + 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NM; i++) m_alive[i] = 1'b0;
    m_pend = 1'b0;
    m_cd   = 0;
    p_draw = 1'b0;
    p_idx  = 0;
  endfunction

  function automatic void model_frame();
    int fs;
    fs = -1;
    for (int i = 0; i < NM; i++) begin
      if (m_alive[i]) begin
        m_x[i] = wrap(m_x[i] + m_vx[i], W * 64);
        m_y[i] = wrap(m_y[i] + m_vy[i], H * 64);
        m_age[i]--;
        if (m_age[i] == 0) m_alive[i] = 1'b0;
      end
    end
    for (int i = NM - 1; i >= 0; i--)
      if (!m_alive[i]) fs = i;
    if (m_pend && m_cd == 0 && fs >= 0) begin
      m_x[fs]     = int'(ship_x) * 64;
      m_y[fs]     = int'(ship_y) * 64;
      m_vx[fs]    = int'(cos_val) >>> 8;
      m_vy[fs]    = -(int'(sin_val) >>> 8);
      m_age[fs]   = LT;
      m_alive[fs] = 1'b1;
      m_cd        = CD;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    m_pend = 1'b0;
  endfunction

  // Per-cycle compare of Draw/RGB/active against the model.
  always @(posedge clk) begin
    bit ed;
    int ei;
    #1;
    ed = 1'b0;
    ei = 0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (m_alive[i] && covers(i, int'(pxl_x), int'(pxl_y))) begin
        ed = 1'b1;
        ei = i;
      end
    end
    if (collision && p_draw) m_alive[p_idx] = 1'b0;
    if (!busy) begin
      chk("cyc_draw", Draw, ed);
      chk("cyc_rgb", {Red, Green, Blue}, ed ? 12'hFFF : 12'h0);
      chk("cyc_active", active, m_active());
    end
    p_draw = ed;
    p_idx  = ei;
  end

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b0;
  endtask

  task automatic pulse_fire();
    @(negedge clk);
    fire   = 1'b1;
    m_pend = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  task automatic do_frame();
    @(negedge clk);
    busy       = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (NM + 3) @(negedge clk);
    model_frame();
    busy = 1'b0;
  endtask

  task automatic probe(input int x, input int y,
                       input bit want, input string name);
    @(negedge clk);
    pxl_x = 10'(x);
    pxl_y = 9'(y);
    @(negedge clk);
    chk(name, Draw, want);
    chk({name, "_rgb"}, {Red, Green, Blue},
        want ? 12'hFFF : 12'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetN     = 1'b1;
    fire       = 1'b0;
    frame_tick = 1'b0;
    collision  = 1'b0;
    ship_x     = 10'd320;
    ship_y     = 9'd240;
    sin_val    = 18'sd0;
    cos_val    = 18'sd65536;
    pxl_x      = 10'd639;
    pxl_y      = 9'd479;
    model_reset();
    #12;
    chk("rst_active", active, 0);
    chk("rst_draw", Draw, 0);
    chk("rst_rgb", {Red, Green, Blue}, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b0;
    busy   = 1'b0;

    // Spawn heading +x, then one step of 4 px.
    do_reset();
    pulse_fire();
    do_frame();
    chk("t35_active", active, 4'b0001);
    probe(320, 240, 1, "t35_at320");
    probe(319, 240, 0, "t35_left");
    probe(321, 241, 1, "t35_corner");
    do_frame();
    chk("t35_model_x", m_x[0] / 64, 324);
    chk("t35_active2", active, 4'b0001);
    probe(324, 240, 1, "t35_at324");
    probe(323, 240, 0, "t35_323");
    probe(325, 241, 1, "t35_325");
    probe(326, 240, 0, "t35_326");

    // Vertical wrap through the top edge.
    do_reset();
    ship_x  = 10'd100;
    ship_y  = 9'd2;
    sin_val = 18'sd65536;
    cos_val = 18'sd0;
    pulse_fire();
    do_frame();
    probe(100, 2, 1, "t36_spawn");
    do_frame();
    chk("t36_model_y1", m_y[0] / 64, 478);
    probe(100, 478, 1, "t36_y478");
    probe(101, 479, 1, "t36_y479");
    probe(100, 477, 0, "t36_y477");
    do_frame();
    chk("t36_model_y2", m_y[0] / 64, 474);
    probe(100, 474, 1, "t36_y474");
    probe(100, 476, 0, "t36_y476");

    // Cooldown: fire edge every frame.
    do_reset();
    sin_val = 18'sd0;
    cos_val = 18'sd65536;
    ship_x  = 10'd320;
    ship_y  = 9'd240;
    for (int f = 1; f <= 19; f++) begin
      pulse_fire();
      do_frame();
      chk($sformatf("t37_f%0d", f), $countones(active),
          f >= 19 ? 3 : (f >= 10 ? 2 : 1));
    end
    // Held fire triggers once.
    do_reset();
    @(negedge clk);
    fire   = 1'b1;
    m_pend = 1'b1;
    repeat (30) do_frame();
    chk("t37_held", $countones(active), 1);
    @(negedge clk);
    fire = 1'b0;

    // Full pool drops the request; lifetime expiry.
    do_reset();
    cos_val = 18'sd0;
    for (int f = 1; f <= 61; f++) begin
      if (f == 1 || f == 10 || f == 19 || f == 28 || f == 40)
        pulse_fire();
      do_frame();
      if (f == 28) chk("t38_full", active, 4'b1111);
      if (f == 40) begin
        chk("t38_drop", active, 4'b1111);
        chk("t38_model_pend", m_pend, 0);
      end
      if (f == 60) chk("t38_f60", active, 4'b1111);
      if (f == 61) chk("t38_expire", active, 4'b1110);
    end

    // Draw and collision kill.
    do_reset();
    ship_x = 10'd100;
    ship_y = 9'd100;
    pulse_fire();
    do_frame();
    @(negedge clk);
    pxl_x     = 10'd300;
    pxl_y     = 9'd300;
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    @(negedge clk);
    chk("t31_ignored", active, 4'b0001);
    probe(101, 101, 1, "t39_draw");
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    @(negedge clk);
    chk("t39_killed", active, 4'b0000);
    probe(100, 100, 0, "t39_dead");

    // Reset in the middle of UPDATE.
    do_reset();
    ship_x = 10'd200;
    ship_y = 9'd200;
    for (int f = 1; f <= 19; f++) begin
      if (f == 1 || f == 10 || f == 19) pulse_fire();
      do_frame();
    end
    chk("t40_three", active, 4'b0111);
    @(negedge clk);
    pxl_x = 10'd200;
    pxl_y = 9'd200;
    @(negedge clk);
    chk("t40_pre_draw", Draw, 1);
    @(negedge clk);
    busy       = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    #1;
    chk("t40_rst_active", active, 0);
    chk("t40_rst_draw", Draw, 0);
    chk("t40_rst_rgb", {Red, Green, Blue}, 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    busy = 1'b0;
    do_frame();
    chk("t40_no_spawn", active, 0);
    @(negedge clk);
    chk("t40_no_draw", Draw, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/missile_unit.md
MISSILE_UNIT -- requirements
Module: missile_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 640, screen width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, screen height in pixels.
REQ-003 SHALL have parameter NUM_MISSILES, default 4, missile slot count.
REQ-004 SHALL have parameter LIFETIME, default 60, frames a missile lives.
REQ-005 SHALL have parameter COOLDOWN, default 8, minimum frames between spawns.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port resetN  input  1  asynchronous, active-high reset (asserted when 1, despite the name).
REQ-008 SHALL have port fire  input  1  fire button level.
REQ-009 SHALL have port frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-010 SHALL have ports ship_x/ship_y  input  clog2(WIDTH)/clog2(HEIGHT)  ship centre.
REQ-011 SHALL have ports sin_val/cos_val  input  18 signed  ship heading, 1.0 = 65536.
REQ-012 SHALL have ports pxl_x/pxl_y  input  clog2(WIDTH)/clog2(HEIGHT)  current scan pixel.
REQ-013 SHALL have port collision  input  1  drawn missile pixel overlaps another object.
REQ-014 SHALL have ports Red/Green/Blue  output  4 each  pixel colour.
REQ-015 SHALL have port Draw  output  1  missile pixel present.
REQ-016 SHALL have port active  output  NUM_MISSILES  per-slot alive mask.

Function
REQ-017 Per slot SHALL store: x Q(clog2(WIDTH)).6, y Q(clog2(HEIGHT)).6, vx/vy 11-bit signed in 1/64 px/frame, 7-bit age, alive bit.
REQ-018 fire rising edge (registered previous value) SHALL set fire_pending; fire held high SHALL NOT re-trigger.
REQ-019 FSM states: IDLE, UPDATE, SPAWN; IDLE -> UPDATE on frame_tick; frame_tick outside IDLE ignored.
REQ-020 UPDATE SHALL process one slot per cycle, index 0..NUM_MISSILES-1, then -> SPAWN.
REQ-021 UPDATE of alive slot: x += vx, y += vy (sign-extended), age -= 1; age reaching 0 clears alive.
REQ-022 Wrap: integer x >= WIDTH -> subtract WIDTH; x < 0 -> add WIDTH; same for y with HEIGHT; fraction preserved.
REQ-023 Cooldown counter SHALL decrement once per frame in SPAWN, saturating at 0.
REQ-024 SPAWN: if fire_pending and cooldown==0 and a free slot exists, lowest free slot gets x=ship_x, y=ship_y (fraction 0), vx = cos_val>>>8, vy = -(sin_val>>>8), age=LIFETIME, alive=1; cooldown=COOLDOWN.
REQ-025 SPAWN SHALL clear fire_pending whether or not a slot was allocated (all full or cooldown -> request dropped); SPAWN -> IDLE after one cycle.
REQ-026 A rising fire edge in the same cycle SPAWN clears fire_pending SHALL remain pending.
REQ-027 Draw SHALL be registered, 1-cycle latency: high when alive slot has pxl_x in [xi, xi+1] and pxl_y in [yi, yi+1] (integer parts, 2x2 square).
REQ-028 When Draw high, Red/Green/Blue SHALL be 4'hF; otherwise 4'h0.
REQ-029 Register the lowest matching slot index alongside Draw; collision with Draw high SHALL clear that slot's alive bit next cycle.
REQ-030 Collision kill and UPDATE of the same slot in the same cycle: kill wins, slot ends dead.
REQ-031 Collision with Draw low SHALL be ignored.
REQ-032 active SHALL mirror the alive bits combinationally from registers.

Reset
REQ-033 resetN high SHALL immediately clear all alive bits, fire_pending, cooldown, Draw, colour outputs, and force IDLE, including mid-UPDATE/SPAWN.
REQ-034 After reset release, first action SHALL be the next frame_tick; no stale spawn.

Verification
REQ-035 Reset, ship (320,240), cos=65536, sin=0, fire pulse, frame_tick -> slot 0 alive, x=320; next frame x=324, active=4'b0001.
REQ-036 sin=65536, cos=0, ship y=2 -> after one frame y=478 (wrap), after another y=474.
REQ-037 Fire edge every frame, COOLDOWN=8 -> spawns only on frames 1, 10, 19; fire held high 30 frames -> exactly one spawn.
REQ-038 Fill 4 slots, fire again -> no change, fire_pending cleared; after LIFETIME=60 frames slot 0 dies, active=4'b1110.
REQ-039 Missile at (100,100): pxl (101,101) -> Draw=1, RGB=FFF one cycle later; collision then -> slot dead, Draw=0 on (100,100) next line.
REQ-040 Assert resetN during UPDATE with 3 alive slots -> active=0, Draw=0 immediately; next frame_tick with no fire -> no spawn.
